// File: rtl/writeback_queue.sv
// writeback_queue: in-order buffer of completed results draining into the register file write port.
// Ports: EnqValid_i/EnqReady_o/EnqRegister_i/EnqData_i accept results; Drain_i permits the head write;
// Flush_i discards everything; LookupRegisterN_i -> PendingN_o/ForwardDataN_o for decode stall/bypass;
// RegWrite_o/WriteRegister_o/WriteData_o drive the register file; Count_o/Full_o/Empty_o report occupancy.
module writeback_queue #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  EnqValid_i,
  output logic                  EnqReady_o,
  input  logic [ADDR_WIDTH-1:0] EnqRegister_i,
  input  logic [DATA_WIDTH-1:0] EnqData_i,
  input  logic                  Drain_i,
  input  logic                  Flush_i,
  input  logic [ADDR_WIDTH-1:0] LookupRegister1_i,
  input  logic [ADDR_WIDTH-1:0] LookupRegister2_i,
  output logic                  Pending1_o,
  output logic                  Pending2_o,
  output logic [DATA_WIDTH-1:0] ForwardData1_o,
  output logic [DATA_WIDTH-1:0] ForwardData2_o,
  output logic                  RegWrite_o,
  output logic [ADDR_WIDTH-1:0] WriteRegister_o,
  output logic [DATA_WIDTH-1:0] WriteData_o,
  output logic [CNT_WIDTH-1:0]  Count_o,
  output logic                  Full_o,
  output logic                  Empty_o
);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, k;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] reg_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [ADDR_WIDTH-1:0] lk [2];
  logic [DATA_WIDTH-1:0] fwd [2];
  logic [1:0] pend;
  logic enq, deq;
  assign Full_o = count_q == CNT_WIDTH'(DEPTH);
  assign Empty_o = count_q == '0;
  assign Count_o = count_q;
  // Readiness uses registered occupancy only; a pop in the same cycle does not free a slot.
  assign EnqReady_o = rst_n && !Full_o && !Flush_i;
  // x0 writes complete the handshake but never allocate an entry.
  assign enq = EnqValid_i && EnqReady_o && EnqRegister_i != '0;
  assign deq = rst_n && !Empty_o && Drain_i && !Flush_i;
  assign RegWrite_o = deq;
  assign WriteRegister_o = Empty_o ? '0 : reg_q[head_q];
  assign WriteData_o = Empty_o ? '0 : data_q[head_q];
  assign lk[0] = LookupRegister1_i;
  assign lk[1] = LookupRegister2_i;
  assign Pending1_o = pend[0];
  assign Pending2_o = pend[1];
  assign ForwardData1_o = fwd[0];
  assign ForwardData2_o = fwd[1];
  always_comb begin
    head_d = deq ? head_q + 1'b1 : head_q;
    tail_d = enq ? tail_q + 1'b1 : tail_q;
    count_d = count_q + CNT_WIDTH'(enq) - CNT_WIDTH'(deq);
    valid_d = valid_q;
    if (enq) valid_d[tail_q] = 1'b1;
    if (deq) valid_d[head_q] = 1'b0;
    if (Flush_i) begin
      head_d = '0;
      tail_d = '0;
      count_d = '0;
      valid_d = '0;
    end
  end
  // Scan oldest to youngest so the last match wins and the youngest value is forwarded.
  always_comb begin
    k = '0;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0;
      fwd[p] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        k = head_q + PW'(i);
        if (valid_q[k] && reg_q[k] == lk[p] && lk[p] != '0) begin
          pend[p] = 1'b1;
          fwd[p] = data_q[k];
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
    if (enq) begin
      reg_q[tail_q] <= EnqRegister_i;
      data_q[tail_q] <= EnqData_i;
    end
  end
endmodule
